// File: rtl/adder_sched_pkg.sv
// Shared constants and the registered response type for the adder scheduler.
// The response id field is sized for the largest supported requester count.
package adder_sched_pkg;

   localparam int DFLT_NUM_REQ = 4;
   localparam int ADDER_W      = 32;
   localparam int ID_W         = $clog2(DFLT_NUM_REQ);
   localparam int ID_MAX_W     = 3;

   typedef struct packed {
      logic [ADDER_W-1:0]  sum;
      logic                cout;
      logic                ovf;
      logic [ID_MAX_W-1:0] id;
   } resp_t;

   // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/carry_select_adder.sv
// 32-bit carry-select adder: each block precomputes sums for carry-in 0 and 1,
// and the rippling block carry only drives the select muxes.
module carry_select_adder #(
   parameter int BLK = 4
) (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   localparam int NB = 32 / BLK;

   logic [NB:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NB; i++) begin : g_blk
      logic [BLK:0] s0;
      logic [BLK:0] s1;

      assign s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
      assign s1 = s0 + {{BLK{1'b0}}, 1'b1};

      assign sum[i*BLK +: BLK] = c[i] ? s1[BLK-1:0] : s0[BLK-1:0];
      assign c[i+1]            = c[i] ? s1[BLK]     : s0[BLK];
   end

   assign cout = c[NB];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N.
// The pointer register lives in the parent so it only advances on a real accept.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_id,
   output logic          any
);

   always_comb begin
      int idx;
      idx    = 0;
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      for (int off = 0; off < N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any         = 1'b1;
            gnt[idx]    = 1'b1;
            gnt_id      = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one carry_select_adder among NUM_REQ requesters with round-robin
// arbitration, per-requester saved carries and a one-cycle registered response.
module adder_scheduler
   import adder_sched_pkg::*;
#(
   parameter int NUM_REQ = DFLT_NUM_REQ,
   parameter int WIDTH   = ADDER_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ-1:0]         req_cin,
   input  logic [NUM_REQ-1:0]         req_chain,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic [WIDTH-1:0]           resp_sum,
   output logic                       resp_cout,
   output logic                       resp_ovf,
   output logic [15:0]                ops_count
);

   localparam int RID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] gnt;
   logic [RID_W-1:0]   gnt_id;
   logic               any;
   logic               accept;

   logic [RID_W-1:0]   ptr_q;
   logic [NUM_REQ-1:0] carry_q;
   resp_t              resp_q;

   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;
   logic               cin_sel;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;
   logic               add_ovf;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (RID_W)
   ) u_arb (
      .req    (req_valid),
      .ptr    (ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   // Grants are masked during reset so nothing is consumed in a reset cycle.
   assign req_ready = rst ? '0 : gnt;
   assign accept    = any & ~rst;

   // The saved carry is the registered value, so a back-to-back chained accept
   // from the same requester sees the carry written on the previous edge.
   always_comb begin
      a_sel   = req_a[gnt_id*WIDTH +: WIDTH];
      b_sel   = req_b[gnt_id*WIDTH +: WIDTH];
      cin_sel = req_chain[gnt_id] ? carry_q[gnt_id] : req_cin[gnt_id];
   end

   carry_select_adder u_add (
      .a    (a_sel),
      .b    (b_sel),
      .cin  (cin_sel),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign add_ovf = signed_ovf(a_sel[WIDTH-1], b_sel[WIDTH-1], add_sum[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         carry_q    <= '0;
         resp_valid <= '0;
         resp_q     <= '0;
         ops_count  <= '0;
      end else begin
         resp_valid <= '0;
         if (accept) begin
            ptr_q           <= (gnt_id == RID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            carry_q[gnt_id] <= add_cout;
            resp_valid      <= gnt;
            resp_q.sum      <= add_sum;
            resp_q.cout     <= add_cout;
            resp_q.ovf      <= add_ovf;
            resp_q.id       <= ID_MAX_W'(gnt_id);
            ops_count       <= ops_count + 16'd1;
         end
      end
   end

   assign resp_sum  = resp_q.sum;
   assign resp_cout = resp_q.cout;
   assign resp_ovf  = resp_q.ovf;
   assign resp_id   = RID_W'(resp_q.id);

endmodule

// File: tb/tb_adder_scheduler.sv
// Self-checking bench for adder_scheduler: directed table, hand sequences for
// round-robin and reset, then randomized traffic against a behavioural model.
module tb_adder_scheduler;

   localparam int NUM_REQ = 4;
   localparam int W       = 32;
   localparam longint S_MAX = 64'sh7FFF_FFFF;
   localparam longint S_MIN = -S_MAX - 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*W-1:0]   req_a;
   logic [NUM_REQ*W-1:0]   req_b;
   logic [NUM_REQ-1:0]     req_cin;
   logic [NUM_REQ-1:0]     req_chain;
   logic [NUM_REQ-1:0]     resp_valid;
   logic [1:0]             resp_id;
   logic [W-1:0]           resp_sum;
   logic                   resp_cout;
   logic                   resp_ovf;
   logic [15:0]            ops_count;

   always #5 clk = ~clk;

   adder_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_cin    (req_cin),
      .req_chain  (req_chain),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .resp_ovf   (resp_ovf),
      .ops_count  (ops_count)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   int                 m_ptr;
   logic               m_carry [NUM_REQ];
   logic [NUM_REQ-1:0] m_valid;
   logic [W-1:0]       m_sum;
   logic               m_cout;
   logic               m_ovf;
   int                 m_id;
   int unsigned        m_ops;

   typedef struct {
      int         id;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        chain;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      for (int i = 0; i < NUM_REQ; i++) m_carry[i] = 1'b0;
      m_valid = '0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
      m_id    = 0;
      m_ops   = 0;
   endtask

   task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic chain);
      req_valid[i]     = v;
      req_a[i*W +: W]  = a;
      req_b[i*W +: W]  = b;
      req_cin[i]       = cin;
      req_chain[i]     = chain;
   endtask

   // Drives one clock with the currently applied inputs and checks both the
   // combinational grant and the registered response against the model.
   task automatic run_cycle(output int g);
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [32:0] full;
      longint      sa;
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NUM_REQ;
         if (g < 0 && req_valid[idx]) g = idx;
      end
      #1;
      chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      if (g >= 0) begin
         a    = req_a[g*W +: W];
         b    = req_b[g*W +: W];
         cin  = req_chain[g] ? m_carry[g] : req_cin[g];
         full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
         sa   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
         m_sum      = full[31:0];
         m_cout     = full[32];
         m_ovf      = (sa > S_MAX) || (sa < S_MIN);
         m_id       = g;
         m_ptr      = (g + 1) % NUM_REQ;
         m_carry[g] = full[32];
         m_ops      = (m_ops + 1) % 65536;
         m_valid    = NUM_REQ'(1) << g;
      end else begin
         m_valid = '0;
      end
      @(posedge clk);
      #1;
      chk("resp_valid", resp_valid, m_valid);
      chk("resp_id",    resp_id,    m_id);
      chk("resp_sum",   resp_sum,   m_sum);
      chk("resp_cout",  resp_cout,  m_cout);
      chk("resp_ovf",   resp_ovf,   m_ovf);
      chk("ops_count",  ops_count,  m_ops);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("ready_in_reset", req_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_sum",   resp_sum,   0);
      chk("rst_resp_id",    resp_id,    0);
      chk("rst_ops_count",  ops_count,  0);
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int g;

      vt[0] = '{0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
      vt[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vt[2] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
      vt[3] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vt[4] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vt[5] = '{3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
      vt[6] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vt[7] = '{2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0};

      rst       = 1'b1;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      req_chain = '0;
      model_reset();
      do_reset();

      // Directed table, one requester valid at a time
      for (int i = 0; i < 8; i++) begin
         req_valid = '0;
         set_req(vt[i].id, 1'b1, vt[i].a, vt[i].b, vt[i].cin, vt[i].chain);
         run_cycle(g);
         chk("tbl_grant", g, vt[i].id);
         chk("tbl_sum",   resp_sum,  vt[i].sum);
         chk("tbl_cout",  resp_cout, vt[i].cout);
         chk("tbl_ovf",   resp_ovf,  vt[i].ovf);
         chk("tbl_ops",   ops_count, i + 1);
      end

      // Idle cycle: no pulse, data holds
      req_valid = '0;
      run_cycle(g);
      chk("idle_hold_sum", resp_sum, 32'h0000_0001);

      // Round-robin from ptr=0 with everyone valid
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         run_cycle(g);
         chk("rr_grant",   g,       k % NUM_REQ);
         chk("rr_resp_id", resp_id, k % NUM_REQ);
      end
      req_valid = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         run_cycle(g);
         chk("solo_grant",   g,       2);
         chk("solo_resp_id", resp_id, 2);
      end

      // Reset right after an accept that leaves carry_q[2]=1
      req_valid = '0;
      set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_cycle(g);
      chk("pre_rst_cout", resp_cout, 1'b1);
      set_req(2, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
      do_reset();
      req_valid = '1;
      run_cycle(g);
      chk("post_rst_ptr0", g, 0);
      req_valid = 4'b0100;
      run_cycle(g);
      chk("post_rst_chain_sum",  resp_sum,  32'h0);
      chk("post_rst_chain_cout", resp_cout, 1'b0);

      // Randomized traffic; a requester holds its request until granted
      req_valid = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) != 0)
               set_req(i, 1'b1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         run_cycle(g);
         if (g >= 0) req_valid[g] = 1'b0;
         if (c == 200) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
